// File: rtl/cpu_sequencer.sv
// cpu_sequencer: accumulator-machine instruction sequencer.
// Fetches a one-byte opcode plus an optional operand-address byte from a
// 16-byte memory and executes LD/ADD/SUB/AND/OR/STO/HALT on an 8-bit acc.
// Optional feature macro: SINGLE_STEP_EN adds the 'step' input, which gates
// advancement out of FETCH_OP.
//
// state       | meaning
// ------------+-------------------------------------------------------
// FETCH_OP    | read opcode byte at pc into ir, pc+1
// FETCH_ADDR  | read operand-address byte at pc into mar, pc+1
// READ_OPND   | read operand at mar into mdr
// EXEC        | apply ALU op to acc / flags
// STORE       | drive acc to mem[mar] with mem_sto_n low for one cycle
// HALTED      | frozen until reset
`timescale 1ns/1ps

module cpu_sequencer #(
  parameter logic [3:0] START_ADDR = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic [3:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_wdata,
  output logic       mem_sto_n,
  output logic [7:0] acc,
  output logic [3:0] pc,
  output logic       zero,
  output logic       carry,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH_OP   = 3'd0,
    S_FETCH_ADDR = 3'd1,
    S_READ_OPND  = 3'd2,
    S_EXEC       = 3'd3,
    S_STORE      = 3'd4,
    S_HALTED     = 3'd5
  } state_t;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_STO = 4'h5;
  localparam logic [7:0] HALT_BYTE = 8'h16;

  state_t     r_state;
  logic [3:0] r_pc;
  logic [7:0] r_acc;
  logic       r_zero;
  logic       r_carry;
  logic [7:0] r_ir;
  logic [3:0] r_mar;
  logic [7:0] r_mdr;
  logic       r_sto_n;
  logic       r_halted;

  logic       w_advance;
  logic       w_op_valid;
  logic [3:0] w_op;
  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic [7:0] w_acc_next;
  logic       w_carry_next;

`ifdef SINGLE_STEP_EN
  assign w_advance = step;
`else
  assign w_advance = 1'b1;
`endif

  // Opcodes 0..6 under the 0001 prefix are real instructions; everything
  // else (other prefixes, 7..F) falls through as a two-byte NOP.
  assign w_op       = r_ir[3:0];
  assign w_op_valid = (r_ir[7:4] == 4'b0001) && (r_ir[3:0] <= 4'h6);

  assign w_sum  = {1'b0, r_acc} + {1'b0, r_mdr};
  assign w_diff = {1'b0, r_acc} - {1'b0, r_mdr};

  // ALU result for the EXEC cycle; carry is only touched by ADD and SUB.
  always_comb begin
    w_acc_next   = r_acc;
    w_carry_next = r_carry;
    case (w_op)
      OP_LD:  w_acc_next = r_mdr;
      OP_ADD: begin
        w_acc_next   = w_sum[7:0];
        w_carry_next = w_sum[8];
      end
      OP_SUB: begin
        w_acc_next   = w_diff[7:0];
        w_carry_next = w_diff[8];
      end
      OP_AND: w_acc_next = r_acc & r_mdr;
      OP_OR:  w_acc_next = r_acc | r_mdr;
      default: ;
    endcase
  end

  // Main sequencer FSM; strobe and halted flag are registered alongside state
  // so they both clear asynchronously with reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH_OP;
      r_pc     <= START_ADDR;
      r_acc    <= 8'h00;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ir     <= 8'h00;
      r_mar    <= 4'h0;
      r_mdr    <= 8'h00;
      r_sto_n  <= 1'b1;
      r_halted <= 1'b0;
    end else begin
      r_sto_n <= 1'b1;
      case (r_state)
        S_FETCH_OP: begin
          if (w_advance) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + 4'h1;
            if (mem_rdata == HALT_BYTE) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state <= S_FETCH_ADDR;
            end
          end
        end
        S_FETCH_ADDR: begin
          r_mar <= mem_rdata[3:0];
          r_pc  <= r_pc + 4'h1;
          if (w_op_valid && (w_op == OP_STO)) begin
            r_state <= S_STORE;
            r_sto_n <= 1'b0;
          end else if (w_op_valid) begin
            r_state <= S_READ_OPND;
          end else begin
            r_state <= S_FETCH_OP;
          end
        end
        S_READ_OPND: begin
          r_mdr   <= mem_rdata;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_acc   <= w_acc_next;
          r_carry <= w_carry_next;
          r_zero  <= (w_acc_next == 8'h00);
          r_state <= S_FETCH_OP;
        end
        S_STORE: begin
          r_state <= S_FETCH_OP;
        end
        S_HALTED: begin
          r_state  <= S_HALTED;
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= S_FETCH_OP;
        end
      endcase
    end
  end

  assign mem_addr  = ((r_state == S_READ_OPND) || (r_state == S_STORE)) ? r_mar : r_pc;
  assign mem_wdata = r_acc;
  assign mem_sto_n = r_sto_n;
  assign acc       = r_acc;
  assign pc        = r_pc;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign halted    = r_halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed programs push timed register
// expectations and expected store strobes; a negedge monitor pops and compares.
// A second instance with START_ADDR=F covers the opcode/operand pc wrap.
`timescale 1ns/1ps

module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef SINGLE_STEP_EN
  logic step = 1'b1;
`endif

  logic [3:0] addr_a, addr_b, pc_a, pc_b;
  logic [7:0] rdata_a, rdata_b, wdata_a, wdata_b, acc_a, acc_b;
  logic       sto_n_a, sto_n_b, zero_a, zero_b, carry_a, carry_b, halted_a, halted_b;

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  logic [7:0] prog_a [16];
  logic [7:0] prog_b [16];

  cpu_sequencer #(.START_ADDR(4'h0)) u_dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .mem_addr(addr_a), .mem_rdata(rdata_a), .mem_wdata(wdata_a), .mem_sto_n(sto_n_a),
    .acc(acc_a), .pc(pc_a), .zero(zero_a), .carry(carry_a), .halted(halted_a)
  );

  cpu_sequencer #(.START_ADDR(4'hF)) u_dut_f (
    .clk(clk), .rst_n(rst_n),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .mem_addr(addr_b), .mem_rdata(rdata_b), .mem_wdata(wdata_b), .mem_sto_n(sto_n_b),
    .acc(acc_b), .pc(pc_b), .zero(zero_b), .carry(carry_b), .halted(halted_b)
  );

  assign rdata_a = mem_a[addr_a];
  assign rdata_b = mem_b[addr_b];

  // memories reload their program while reset is held, and take stores
  always @(posedge clk) begin
    if (!rst_n) mem_a <= prog_a;
    else if (!sto_n_a) mem_a[addr_a] <= wdata_a;
  end

  always @(posedge clk) begin
    if (!rst_n) mem_b <= prog_b;
    else if (!sto_n_b) mem_b[addr_b] <= wdata_b;
  end

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  typedef enum int {SIG_ACC, SIG_PC, SIG_ZERO, SIG_CARRY, SIG_HALTED, SIG_ADDR,
                    SIG_ACC_B, SIG_PC_B, SIG_HALTED_B} sig_e;
  typedef struct {int cyc; sig_e sig; logic [7:0] val;} exp_t;
  typedef struct {logic [3:0] addr; logic [7:0] data;} sto_t;

  exp_t exp_q[$];
  sto_t sto_q[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [7:0] sig_val(sig_e s);
    case (s)
      SIG_ACC:      return acc_a;
      SIG_PC:       return {4'h0, pc_a};
      SIG_ZERO:     return {7'h0, zero_a};
      SIG_CARRY:    return {7'h0, carry_a};
      SIG_HALTED:   return {7'h0, halted_a};
      SIG_ADDR:     return {4'h0, addr_a};
      SIG_ACC_B:    return acc_b;
      SIG_PC_B:     return {4'h0, pc_b};
      SIG_HALTED_B: return {7'h0, halted_b};
      default:      return 8'hxx;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_at(input int c, input sig_e s, input logic [7:0] v);
    exp_t e;
    e.cyc = c; e.sig = s; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_store(input logic [3:0] a, input logic [7:0] d);
    sto_t s;
    s.addr = a; s.data = d;
    sto_q.push_back(s);
  endtask

  // monitor: timed expectations and store strobes, sampled on the falling edge
  exp_t m_e;
  sto_t m_s;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        m_e = exp_q.pop_front();
        if (m_e.cyc < cyc) begin
          n_checks++; n_fail++;
          $display("FAIL missed_%s: cycle %0d passed, now %0d", m_e.sig.name(), m_e.cyc, cyc);
        end else begin
          check($sformatf("%s@%0d", m_e.sig.name(), m_e.cyc), sig_val(m_e.sig), m_e.val);
        end
      end
      if (sto_n_a === 1'b0) begin
        if (sto_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_store: addr %h data %h at cycle %0d, none expected",
                   addr_a, wdata_a, cyc);
        end else begin
          m_s = sto_q.pop_front();
          check($sformatf("store_addr@%0d", cyc), {4'h0, addr_a}, {4'h0, m_s.addr});
          check($sformatf("store_data@%0d", cyc), wdata_a, m_s.data);
        end
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog_a[i] = 8'h00;
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    sto_q.delete();
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_cycles(input int n, input string tag);
    repeat (n) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || sto_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d timed and %0d store expectations left, required 0",
               tag, exp_q.size(), sto_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) prog_b[i] = 8'h00;
    prog_b[4'hF] = 8'h10; prog_b[4'h0] = 8'h03; prog_b[4'h1] = 8'h16; prog_b[4'h3] = 8'h5A;

    // ---- program 1: LD, HALT freeze, plus wrap on the START_ADDR=F instance
    enter_reset();
    clear_prog();
    prog_a[0] = 8'h10; prog_a[1] = 8'h0A; prog_a[2] = 8'h16; prog_a[4'hA] = 8'h05;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", {4'h0, pc_a}, 8'h00);
    check("rst_acc", acc_a, 8'h00);
    check("rst_zero", {7'h0, zero_a}, 8'h00);
    check("rst_carry", {7'h0, carry_a}, 8'h00);
    check("rst_halted", {7'h0, halted_a}, 8'h00);
    check("rst_sto_n", {7'h0, sto_n_a}, 8'h01);
    check("rst_pc_b", {4'h0, pc_b}, 8'h0F);
    expect_at(1, SIG_PC, 8'h01);  expect_at(1, SIG_PC_B, 8'h00);
    expect_at(4, SIG_ACC, 8'h05); expect_at(4, SIG_ZERO, 8'h00); expect_at(4, SIG_PC, 8'h02);
    expect_at(4, SIG_HALTED, 8'h00);
    expect_at(4, SIG_ACC_B, 8'h5A); expect_at(4, SIG_PC_B, 8'h01);
    expect_at(5, SIG_HALTED, 8'h01); expect_at(5, SIG_PC, 8'h03);
    expect_at(5, SIG_HALTED_B, 8'h01); expect_at(5, SIG_PC_B, 8'h02);
    expect_at(25, SIG_PC, 8'h03); expect_at(25, SIG_HALTED, 8'h01); expect_at(25, SIG_ADDR, 8'h03);
    expect_at(25, SIG_PC_B, 8'h02);
    release_reset();
    run_cycles(26, "prog1");

    // ---- program 2: ADD carry, STO, SUB to zero, SUB with borrow, HALT
    enter_reset();
    clear_prog();
    prog_a[0] = 8'h10; prog_a[1] = 8'h0C; prog_a[2] = 8'h11; prog_a[3] = 8'h0D;
    prog_a[4] = 8'h15; prog_a[5] = 8'h0E; prog_a[6] = 8'h12; prog_a[7] = 8'h0E;
    prog_a[8] = 8'h12; prog_a[9] = 8'h0F; prog_a[4'hA] = 8'h16;
    prog_a[4'hC] = 8'hF0; prog_a[4'hD] = 8'h20; prog_a[4'hF] = 8'h01;
    expect_at(4, SIG_ACC, 8'hF0);
    expect_at(8, SIG_ACC, 8'h10); expect_at(8, SIG_CARRY, 8'h01); expect_at(8, SIG_ZERO, 8'h00);
    expect_at(8, SIG_PC, 8'h04);
    expect_store(4'hE, 8'h10);
    expect_at(10, SIG_PC, 8'h06);
    expect_at(11, SIG_ACC, 8'h10); expect_at(11, SIG_CARRY, 8'h01);
    expect_at(15, SIG_ACC, 8'h00); expect_at(15, SIG_ZERO, 8'h01); expect_at(15, SIG_CARRY, 8'h00);
    expect_at(19, SIG_ACC, 8'hFF); expect_at(19, SIG_CARRY, 8'h01); expect_at(19, SIG_ZERO, 8'h00);
    expect_at(19, SIG_PC, 8'h0A);
    expect_at(20, SIG_HALTED, 8'h01); expect_at(20, SIG_PC, 8'h0B);
    expect_at(40, SIG_PC, 8'h0B); expect_at(40, SIG_HALTED, 8'h01); expect_at(40, SIG_ACC, 8'hFF);
    release_reset();
    run_cycles(41, "prog2");

    // ---- program 3: AND/OR, both NOP flavours, pc wrap F->0
    enter_reset();
    clear_prog();
    prog_a[0] = 8'h10; prog_a[1] = 8'h0D; prog_a[2] = 8'h13; prog_a[3] = 8'h0E;
    prog_a[4] = 8'h14; prog_a[5] = 8'h0C; prog_a[6] = 8'h2A; prog_a[7] = 8'h00;
    prog_a[8] = 8'h17; prog_a[9] = 8'h00; prog_a[4'hA] = 8'h13; prog_a[4'hB] = 8'h0F;
    prog_a[4'hC] = 8'hA0; prog_a[4'hD] = 8'h3C; prog_a[4'hE] = 8'h0F; prog_a[4'hF] = 8'h53;
    expect_at(4, SIG_ACC, 8'h3C);
    expect_at(8, SIG_ACC, 8'h0C); expect_at(8, SIG_ZERO, 8'h00);
    expect_at(12, SIG_ACC, 8'hAC);
    expect_at(14, SIG_PC, 8'h08); expect_at(14, SIG_ACC, 8'hAC);
    expect_at(16, SIG_PC, 8'h0A); expect_at(16, SIG_ACC, 8'hAC);
    expect_at(20, SIG_ACC, 8'h00); expect_at(20, SIG_ZERO, 8'h01); expect_at(20, SIG_CARRY, 8'h00);
    expect_at(20, SIG_PC, 8'h0C);
    expect_at(22, SIG_PC, 8'h0E);
    expect_at(24, SIG_PC, 8'h00); expect_at(24, SIG_ACC, 8'h00); expect_at(24, SIG_ZERO, 8'h01);
    expect_at(28, SIG_ACC, 8'h3C); expect_at(28, SIG_ZERO, 8'h00); expect_at(28, SIG_PC, 8'h02);
    release_reset();
    run_cycles(28, "prog3");

    // ---- program 4: STO of 0x3C to 0xF, reset dropped inside the STORE cycle
    enter_reset();
    clear_prog();
    prog_a[0] = 8'h10; prog_a[1] = 8'h0D; prog_a[2] = 8'h15; prog_a[3] = 8'h0F;
    prog_a[4'hD] = 8'h3C;
    expect_at(4, SIG_ACC, 8'h3C);
    expect_at(5, SIG_PC, 8'h03);
    expect_store(4'hF, 8'h3C);
    expect_at(6, SIG_PC, 8'h04);
    release_reset();
    run_cycles(6, "prog4");
    rst_n = 1'b0;
    #1;
    check("midstore_sto_n", {7'h0, sto_n_a}, 8'h01);
    check("midstore_pc", {4'h0, pc_a}, 8'h00);
    check("midstore_acc", acc_a, 8'h00);
    check("midstore_halted", {7'h0, halted_a}, 8'h00);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter START_ADDR, default 4'h0, is the program counter value loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 mem_addr  output  4  memory address, driven combinationally from state.
REQ-005 mem_rdata  input  8  memory read data, combinational from mem_addr in the same cycle.
REQ-006 mem_wdata  output  8  store data, equal to acc.
REQ-007 mem_sto_n  output  1  active-low store strobe, one cycle per STO.
REQ-008 acc  output  8  accumulator.
REQ-009 pc  output  4  program counter.
REQ-010 zero, carry  output  1 each  ALU flags.
REQ-011 halted  output  1  high in the HALTED state.
REQ-012 step  input  1  single-step advance; present only when SINGLE_STEP_EN is defined.

Function
REQ-013 The instruction byte SHALL be 0001_oooo, where oooo is 0000 LD, 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 STO, 0110 HALT; every instruction except HALT is followed by an operand-address byte whose bits [3:0] form the address.
REQ-014 FSM states SHALL be FETCH_OP, FETCH_ADDR, READ_OPND, EXEC, STORE, HALTED.
REQ-015 FETCH_OP: mem_addr=pc; latch ir=mem_rdata; pc+=1; next state is HALTED for HALT, otherwise FETCH_ADDR.
REQ-016 FETCH_ADDR: mem_addr=pc; latch mar=mem_rdata[3:0]; pc+=1; next state is STORE for STO, otherwise READ_OPND.
REQ-017 READ_OPND: mem_addr=mar; latch mdr=mem_rdata; next state EXEC.
REQ-018 EXEC SHALL apply the following, then return to FETCH_OP:
- LD: acc=mdr.
- ADD: {carry,acc}=acc+mdr (9-bit result).
- SUB: acc=acc-mdr mod 256; carry=1 on borrow (acc<mdr).
- AND / OR: bitwise; carry unchanged.
- zero=(new acc==0) for every EXEC.
REQ-019 STORE: mem_addr=mar, mem_wdata=acc, mem_sto_n=0 for exactly this one cycle; next state FETCH_OP; acc and flags unchanged.
REQ-020 HALTED: halted=1; the FSM stays in HALTED until reset; mem_sto_n=1; mem_addr=pc.
REQ-021 In all states other than STORE, mem_sto_n SHALL be 1.
REQ-022 Instruction latency SHALL be 4 cycles for LD/ADD/SUB/AND/OR, 3 cycles for STO, and 1 cycle to enter HALTED.
REQ-023 A byte whose upper nibble is not 0001, or whose opcode is 0111-1111, SHALL be treated as a 2-byte NOP: FETCH_ADDR, then FETCH_OP, with acc and flags unchanged.
REQ-024 pc SHALL wrap from 4'hF to 4'h0 with no flag or stall; an operand byte fetched across the wrap is legal.

Reset
REQ-025 When rst_n=0, the block SHALL immediately set pc=START_ADDR, acc=0, zero=0, carry=0, ir=0, mar=0, mdr=0, state=FETCH_OP, halted=0, mem_sto_n=1.
REQ-026 Reset asserted mid-instruction, including during STORE, SHALL abort the instruction and deassert mem_sto_n asynchronously.
REQ-027 The first fetch SHALL occur in the first clock cycle after rst_n deasserts.

Configuration
REQ-028 With SINGLE_STEP_EN defined, the FETCH_OP state SHALL advance only in a cycle where step=1; otherwise it holds with pc unchanged. All other states advance unconditionally.
REQ-029 Without SINGLE_STEP_EN, the step port SHALL be absent and FETCH_OP SHALL always advance.

Verification
REQ-030 Load: mem[0]=0x10, mem[1]=0x0A, mem[A]=0x05 -> after 4 cycles acc=0x05, zero=0, pc=2.
REQ-031 ADD carry: acc=0xF0, ADD from an operand address holding 0x20 -> acc=0x10, carry=1, zero=0.
REQ-032 SUB zero and borrow: acc=0x05 SUB 0x05 -> acc=0x00, zero=1, carry=0; then SUB 0x01 -> acc=0xFF, carry=1.
REQ-033 Store: acc=0x3C, bytes 0x15,0x0F -> mem_sto_n=0 for exactly 1 cycle with mem_addr=0xF and mem_wdata=0x3C; then pc+2.
REQ-034 HALT and wrap: pc=0xF holding LD with operand byte at 0x0 -> pc wraps to 0x1; a 0x16 byte -> halted=1 next cycle and pc frozen for 20 cycles.
REQ-035 Reset during STORE: drop rst_n in the STORE cycle -> mem_sto_n=1 immediately, pc=START_ADDR, acc=0.
